// File: rtl/mb_rx_pkg.sv
// Shared definitions for the mainband RX datapath: word/counter widths and
// the deserializer state encoding.
package mb_rx_pkg;

  localparam int MB_WORD_W = 32;
  localparam int MB_WCNT_W = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } mb_rx_state_t;

endpackage

// File: rtl/mb_deserializer.sv
// Mainband RX serial-to-parallel stage. Samples RXDATA/RXVLD on every bit
// clock, assembles MSB-first words and presents each finished word with a
// one-cycle strobe. Valid dropping mid-word discards the partial word and
// raises a one-cycle framing error.
//
// Handshake: o_data_valid is a single-cycle strobe with no backpressure; the
// consumer must capture o_data_out in the cycle o_data_valid is high. The
// word stays on o_data_out until the next strobe (or reset).
module mb_deserializer
  import mb_rx_pkg::*;
#(
  parameter int WIDTH = MB_WORD_W,
  parameter int CNT_W = MB_WCNT_W
) (
  input  logic               i_pll_clk,
  input  logic               i_rst_n,
  input  logic               i_enable,
  input  logic               RXDATA,
  input  logic               RXVLD,
  output logic [WIDTH-1:0]   o_data_out,
  output logic               o_data_valid,
  output logic               o_frame_err,
  output logic [CNT_W-1:0]   o_word_count,
  output mb_rx_state_t       o_state
);

  localparam int BC_W = $clog2(WIDTH);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WIDTH - 1);

  mb_rx_state_t      state;
  mb_rx_state_t      state_nxt;
  logic [BC_W-1:0]   bit_cnt;
  logic [BC_W-1:0]   cnt_nxt;
  logic [WIDTH-1:0]  shreg;
  logic [WIDTH-1:0]  shift_word;
  logic              shift_en;
  logic              word_done;
  logic              ferr_nxt;

  // Shift register contents after taking the current sample.
  assign shift_word = {shreg[WIDTH-2:0], RXDATA};
  assign o_state    = state;

  // FSM state and bit counter register.
  always_ff @(posedge i_pll_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= cnt_nxt;
    end
  end

  // Next-state, bit counter and datapath control decode.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = bit_cnt;
    shift_en  = 1'b0;
    word_done = 1'b0;
    ferr_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (i_enable && RXVLD) begin
          shift_en  = 1'b1;
          cnt_nxt   = BC_W'(1);
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (!i_enable) begin
          // Link FSM pulled enable: drop the partial word silently.
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (RXVLD) begin
          shift_en = 1'b1;
          if (bit_cnt == LAST_BIT) begin
            // Stay in SHIFT so a contiguous next word loses no UI.
            word_done = 1'b1;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = bit_cnt + 1'b1;
          end
        end else begin
          // Valid gap: clean at a word boundary, a framing error otherwise.
          state_nxt = IDLE;
          cnt_nxt   = '0;
          ferr_nxt  = (bit_cnt != '0);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Shift register, word output, strobes and saturating word counter.
  always_ff @(posedge i_pll_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shreg        <= '0;
      o_data_out   <= '0;
      o_data_valid <= 1'b0;
      o_frame_err  <= 1'b0;
      o_word_count <= '0;
    end else begin
      if (shift_en) begin
        shreg <= shift_word;
      end
      if (word_done) begin
        o_data_out <= shift_word;
        if (o_word_count != '1) begin
          o_word_count <= o_word_count + 1'b1;
        end
      end
      o_data_valid <= word_done;
      o_frame_err  <= ferr_nxt;
    end
  end

endmodule

// File: tb/tb_mb_deserializer.sv
// Directed bench for mb_deserializer: one default-width instance plus a
// CNT_W=2 instance sharing the same stimulus for counter saturation.
module tb_mb_deserializer;
  import mb_rx_pkg::*;

  localparam int W = 32;

  // Clock / reset
  logic i_pll_clk = 1'b0;
  logic i_rst_n   = 1'b0;
  logic i_enable  = 1'b0;
  logic RXDATA    = 1'b0;
  logic RXVLD     = 1'b0;
  always #5 i_pll_clk = ~i_pll_clk;

  logic [W-1:0]   o_data_out;
  logic           o_data_valid;
  logic           o_frame_err;
  logic [15:0]    o_word_count;
  mb_rx_state_t   o_state;

  logic [W-1:0]   s_data_out;
  logic           s_data_valid;
  logic           s_frame_err;
  logic [1:0]     s_word_count;
  mb_rx_state_t   s_state;

  mb_deserializer #(.WIDTH(W), .CNT_W(16)) u_dut (
    .i_pll_clk    (i_pll_clk),
    .i_rst_n      (i_rst_n),
    .i_enable     (i_enable),
    .RXDATA       (RXDATA),
    .RXVLD        (RXVLD),
    .o_data_out   (o_data_out),
    .o_data_valid (o_data_valid),
    .o_frame_err  (o_frame_err),
    .o_word_count (o_word_count),
    .o_state      (o_state)
  );

  mb_deserializer #(.WIDTH(W), .CNT_W(2)) u_sat (
    .i_pll_clk    (i_pll_clk),
    .i_rst_n      (i_rst_n),
    .i_enable     (i_enable),
    .RXDATA       (RXDATA),
    .RXVLD        (RXVLD),
    .o_data_out   (s_data_out),
    .o_data_valid (s_data_valid),
    .o_frame_err  (s_frame_err),
    .o_word_count (s_word_count),
    .o_state      (s_state)
  );

  // Scoreboard state
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int ncyc = 0;
  int strobe_cnt = 0;
  int ferr_cnt = 0;
  int strobe_cyc[$];
  logic [W-1:0] prev_data = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: compares every strobe against the expected queue and watches
  // the output invariants.
  always @(negedge i_pll_clk) begin
    ncyc++;
    if (!i_rst_n) begin
      prev_data = '0;
    end else begin
      if (o_data_valid) begin
        strobe_cnt++;
        strobe_cyc.push_back(ncyc);
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", {32'h0, o_data_out}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          check("strobe_data", {32'h0, o_data_out}, {32'h0, exp_q.pop_front()});
        end
      end else if (o_data_out !== prev_data) begin
        check("data_hold", {32'h0, o_data_out}, {32'h0, prev_data});
      end
      if (o_frame_err) begin
        ferr_cnt++;
        if (o_data_valid) check("valid_and_ferr", 64'd1, 64'd0);
      end
      prev_data = o_data_out;
    end
  end

  // Driver tasks: inputs change on the falling edge, DUT samples on rising.
  task automatic drive(input logic en, input logic vld, input logic d);
    @(negedge i_pll_clk);
    i_enable = en;
    RXVLD    = vld;
    RXDATA   = d;
  endtask

  task automatic send_bits(input logic [W-1:0] w, input int n);
    for (int i = W - 1; i >= W - n; i--) drive(1'b1, 1'b1, w[i]);
  endtask

  task automatic send_word(input logic [W-1:0] w);
    send_bits(w, W);
  endtask

  task automatic do_reset();
    @(negedge i_pll_clk);
    i_rst_n  = 1'b0;
    i_enable = 1'b0;
    RXVLD    = 1'b0;
    RXDATA   = 1'b0;
    exp_q.delete();
    strobe_cyc.delete();
    strobe_cnt = 0;
    ferr_cnt   = 0;
    repeat (2) @(negedge i_pll_clk);
    i_rst_n = 1'b1;
    drive(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge i_pll_clk);
    check("rst_data", {32'h0, o_data_out}, 64'h0);
    check("rst_valid", {63'h0, o_data_valid}, 64'h0);
    check("rst_ferr", {63'h0, o_frame_err}, 64'h0);
    check("rst_count", {48'h0, o_word_count}, 64'h0);
    check("rst_state", {63'h0, o_state}, {63'h0, IDLE});
    check("rst_sat_count", {62'h0, s_word_count}, 64'h0);
    i_rst_n = 1'b1;
    drive(1'b1, 1'b0, 1'b0);

    // Single word with latency check
    exp_q.push_back(32'hA5A50F0F);
    send_word(32'hA5A50F0F);
    check("single_valid_early", {63'h0, o_data_valid}, 64'h0);
    drive(1'b1, 1'b0, 1'b0);
    check("single_valid_lat1", {63'h0, o_data_valid}, 64'h1);
    check("single_data", {32'h0, o_data_out}, 64'hA5A50F0F);
    check("single_count", {48'h0, o_word_count}, 64'd1);
    drive(1'b1, 1'b0, 1'b0);
    check("single_valid_pulse", {63'h0, o_data_valid}, 64'h0);
    check("single_strobes", strobe_cnt, 1);
    check("single_ferr", ferr_cnt, 0);

    // Back-to-back words
    do_reset();
    exp_q.push_back(32'hDEADBEEF);
    exp_q.push_back(32'h12345678);
    send_word(32'hDEADBEEF);
    send_word(32'h12345678);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    check("b2b_strobes", strobe_cnt, 2);
    if (strobe_cyc.size() == 2) check("b2b_spacing", strobe_cyc[1] - strobe_cyc[0], 32);
    else check("b2b_spacing_n", strobe_cyc.size(), 2);
    check("b2b_count", {48'h0, o_word_count}, 64'd2);
    check("b2b_last", {32'h0, o_data_out}, 64'h12345678);
    check("b2b_ferr", ferr_cnt, 0);

    // Framing error after 10 bits
    do_reset();
    send_bits(32'hFFFFFFFF, 10);
    drive(1'b1, 1'b0, 1'b0);
    check("ferr_not_yet", {63'h0, o_frame_err}, 64'h0);
    drive(1'b1, 1'b0, 1'b0);
    check("ferr_pulse", {63'h0, o_frame_err}, 64'h1);
    check("ferr_state", {63'h0, o_state}, {63'h0, IDLE});
    drive(1'b1, 1'b0, 1'b0);
    check("ferr_one_cycle", {63'h0, o_frame_err}, 64'h0);
    check("ferr_no_strobe", strobe_cnt, 0);
    check("ferr_data_kept", {32'h0, o_data_out}, 64'h0);
    exp_q.push_back(32'h00000001);
    send_word(32'h00000001);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    check("ferr_next_strobes", strobe_cnt, 1);
    check("ferr_next_data", {32'h0, o_data_out}, 64'h1);
    check("ferr_count", {48'h0, o_word_count}, 64'd1);
    check("ferr_total", ferr_cnt, 1);

    // Enable drop after 20 bits; RXVLD/RXDATA keep toggling while disabled
    do_reset();
    send_bits(32'hFFFFFFFF, 20);
    drive(1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b1);
    check("en_state", {63'h0, o_state}, {63'h0, IDLE});
    exp_q.push_back(32'hCAFEF00D);
    send_word(32'hCAFEF00D);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    check("en_strobes", strobe_cnt, 1);
    check("en_ferr", ferr_cnt, 0);
    check("en_data", {32'h0, o_data_out}, 64'hCAFEF00D);
    check("en_count", {48'h0, o_word_count}, 64'd1);

    // Reset mid-word, with a previous word held on the output
    do_reset();
    exp_q.push_back(32'h5A5A5A5A);
    send_word(32'h5A5A5A5A);
    send_bits(32'hFFFFFFFF, 15);
    @(posedge i_pll_clk);
    #1;
    check("pre_rst_count", {48'h0, o_word_count}, 64'd1);
    i_rst_n = 1'b0;
    #1;
    check("midrst_data", {32'h0, o_data_out}, 64'h0);
    check("midrst_valid", {63'h0, o_data_valid}, 64'h0);
    check("midrst_ferr", {63'h0, o_frame_err}, 64'h0);
    check("midrst_count", {48'h0, o_word_count}, 64'h0);
    check("midrst_state", {63'h0, o_state}, {63'h0, IDLE});
    RXVLD = 1'b0;
    @(negedge i_pll_clk);
    @(negedge i_pll_clk);
    i_rst_n = 1'b1;
    ferr_cnt = 0;
    strobe_cnt = 0;
    exp_q.push_back(32'h0000FFFF);
    send_word(32'h0000FFFF);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    check("postrst_data", {32'h0, o_data_out}, 64'h0000FFFF);
    check("postrst_count", {48'h0, o_word_count}, 64'd1);
    check("postrst_ferr", ferr_cnt, 0);

    // Saturation: CNT_W=2 instance counts 1,2,3,3,3
    do_reset();
    for (int k = 0; k < 5; k++) begin
      logic [W-1:0] w;
      w = 32'h1000_0001 * (k + 3);
      exp_q.push_back(w);
      send_word(w);
      drive(1'b1, 1'b0, 1'b0);
      check("sat_count2", {62'h0, s_word_count}, (k + 1 > 3) ? 64'd3 : 64'(k + 1));
      check("sat_count16", {48'h0, o_word_count}, 64'(k + 1));
      check("sat_data", {32'h0, s_data_out}, {32'h0, w});
    end
    drive(1'b1, 1'b0, 1'b0);
    check("sb_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
